// File: rtl/link_pkg.sv
// link_pkg: FSM states, mode codes and a clog2 helper shared by the link emulator
package link_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, RUN = 2'd2, STOPPING = 2'd3} state_t;
   localparam logic [1:0] MODE_NORMAL   = 2'd0;
   localparam logic [1:0] MODE_NO_NOISE = 2'd1;
   localparam logic [1:0] MODE_BYPASS   = 2'd2;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/channel_with_noise.sv
// channel_with_noise: 2-tap ISI FIR (1 + z^-1/4) plus scaled pseudo-Gaussian noise, saturated
//   clk, rst, in_I/in_Q samples, sigma noise level -> out_I/out_Q (1 cycle latency)
module channel_with_noise #(
   parameter int DWIDTH    = 9,
   parameter int SNR_WIDTH = 11
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [DWIDTH-1:0]    in_I,
   input  logic signed [DWIDTH-1:0]    in_Q,
   input  logic signed [SNR_WIDTH-1:0] sigma,
   output logic signed [DWIDTH-1:0]    out_I,
   output logic signed [DWIDTH-1:0]    out_Q
);
   localparam int MAXV = (1 << (DWIDTH - 1)) - 1;
   logic [15:0] lfsr_q, lfsr_d;
   logic signed [DWIDTH-1:0] xi_q, xq_q, yi_q, yq_q, yi_d, yq_d;
   int gi, gq, si, sq;
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      // sum of four uniform nibbles, centred: a cheap approximately Gaussian variate
      gi = int'(lfsr_q[3:0]) + int'(lfsr_q[7:4]) + int'(lfsr_q[11:8]) + int'(lfsr_q[15:12]) - 30;
      gq = int'(lfsr_q[5:2]) + int'(lfsr_q[9:6]) + int'(lfsr_q[13:10]) + int'({lfsr_q[1:0], lfsr_q[15:14]}) - 30;
      si = int'(in_I) + (int'(xi_q) >>> 2) + ((gi * int'(sigma)) >>> 7);
      sq = int'(in_Q) + (int'(xq_q) >>> 2) + ((gq * int'(sigma)) >>> 7);
      yi_d = DWIDTH'(si > MAXV ? MAXV : si < -MAXV ? -MAXV : si);
      yq_d = DWIDTH'(sq > MAXV ? MAXV : sq < -MAXV ? -MAXV : sq);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 16'hACE1;
         xi_q   <= '0;
         xq_q   <= '0;
         yi_q   <= '0;
         yq_q   <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         xi_q   <= in_I;
         xq_q   <= in_Q;
         yi_q   <= yi_d;
         yq_q   <= yq_d;
      end
   end
   assign out_I = yi_q;
   assign out_Q = yq_q;
endmodule

// File: rtl/link_frame_ctrl.sv
// link_frame_ctrl: run-control FSM, flush/sample/frame counters and frame-synchronous sigma shadow
//   in: start, stop, mode, sigma_scale, sigma_wr; out: core_rst, valid, frame_start, busy, frame_cnt, mode_q, sigma_act
module link_frame_ctrl
   import link_pkg::*;
#(
   parameter int FRAME_LEN    = 1024,
   parameter int FLUSH_CYCLES = 16,
   parameter int FCNT_W       = 16,
   parameter int SNR_WIDTH    = 11
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        stop,
   input  logic [1:0]                  mode,
   input  logic signed [SNR_WIDTH-1:0] sigma_scale,
   input  logic                        sigma_wr,
   output logic                        core_rst,
   output logic                        valid,
   output logic                        frame_start,
   output logic                        busy,
   output logic [FCNT_W-1:0]           frame_cnt,
   output logic [1:0]                  mode_q,
   output logic signed [SNR_WIDTH-1:0] sigma_act
);
   localparam int MAXC = FRAME_LEN > FLUSH_CYCLES ? FRAME_LEN : FLUSH_CYCLES;
   localparam int CW = clog2(MAXC) < 1 ? 1 : clog2(MAXC);
   localparam logic [CW-1:0] LAST_S = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] LAST_F = CW'(FLUSH_CYCLES - 1);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [1:0] mode_d;
   logic signed [SNR_WIDTH-1:0] sh_q, sh_d, act_q, act_d, wr_val;
   logic pend_q, pend_d, running, wrap;
   always_comb begin
      running = state_q == RUN || state_q == STOPPING;
      wrap = running && cnt_q == LAST_S;
      wr_val = sigma_scale[SNR_WIDTH-1] ? '0 : sigma_scale;
      state_d = state_q;
      cnt_d = state_q == IDLE ? '0 : cnt_q + 1'b1;
      fcnt_d = fcnt_q;
      mode_d = mode_q;
      case (state_q)
         IDLE: if (start && !stop) begin
            state_d = FLUSH;
            fcnt_d = '0;
            mode_d = mode;
         end
         FLUSH: if (cnt_q == LAST_F) begin
            state_d = RUN;
            cnt_d = '0;
         end
         RUN: state_d = stop ? (wrap ? IDLE : STOPPING) : RUN;
         default: state_d = wrap ? IDLE : STOPPING;
      endcase
      if (wrap) begin
         cnt_d = '0;
         fcnt_d = fcnt_q + 1'b1;
      end
      // outside a frame the shadow goes live at once; inside, only at the frame boundary
      sh_d = sigma_wr ? wr_val : sh_q;
      act_d = !running ? (sigma_wr ? wr_val : pend_q ? sh_q : act_q) : (wrap && pend_q) ? sh_q : act_q;
      pend_d = running && (sigma_wr || (pend_q && !wrap));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fcnt_q  <= '0;
         mode_q  <= MODE_NORMAL;
         sh_q    <= '0;
         act_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         mode_q  <= mode_d;
         sh_q    <= sh_d;
         act_q   <= act_d;
         pend_q  <= pend_d;
      end
   end
   assign core_rst    = rst | (state_q == IDLE);
   assign valid       = running;
   assign frame_start = running && cnt_q == '0;
   assign busy        = state_q != IDLE;
   assign frame_cnt   = fcnt_q;
   assign sigma_act   = act_q;
endmodule

// File: rtl/tx_top.sv
// tx_top: PRBS-15 source, two bits per clock, QPSK mapped to +/-A on I and Q
//   clk, rst (sync, active-high) -> tx_I, tx_Q registered signed symbols
module tx_top #(
   parameter int DWIDTH = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic signed [DWIDTH-1:0] tx_I,
   output logic signed [DWIDTH-1:0] tx_Q
);
   localparam int A = 1 << (DWIDTH - 3);
   logic [14:0] lfsr_q, lfsr_d;
   logic signed [DWIDTH-1:0] i_q, i_d, q_q, q_d;
   logic b0, b1;
   always_comb begin
      b0 = lfsr_q[14] ^ lfsr_q[13];
      b1 = lfsr_q[13] ^ lfsr_q[12];
      lfsr_d = {lfsr_q[12:0], b0, b1};
      i_d = b0 ? DWIDTH'(-A) : DWIDTH'(A);
      q_d = b1 ? DWIDTH'(-A) : DWIDTH'(A);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= '1;
         i_q    <= '0;
         q_q    <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         i_q    <= i_d;
         q_q    <= q_d;
      end
   end
   assign tx_I = i_q;
   assign tx_Q = q_q;
endmodule

// File: rtl/link_emu_top.sv
// link_emu_top: TX + noisy channel under run control, with flush masking, framing and bypass modes
//   in: start, stop, mode, sigma_scale, sigma_wr; out: rx_I, rx_Q, rx_valid, frame_start, busy, frame_cnt
module link_emu_top
   import link_pkg::*;
#(
   parameter int DWIDTH       = 9,
   parameter int SNR_WIDTH    = 11,
   parameter int FRAME_LEN    = 1024,
   parameter int FLUSH_CYCLES = 16,
   parameter int FCNT_W       = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        stop,
   input  logic [1:0]                  mode,
   input  logic signed [SNR_WIDTH-1:0] sigma_scale,
   input  logic                        sigma_wr,
   output logic signed [DWIDTH-1:0]    rx_I,
   output logic signed [DWIDTH-1:0]    rx_Q,
   output logic                        rx_valid,
   output logic                        frame_start,
   output logic                        busy,
   output logic [FCNT_W-1:0]           frame_cnt
);
   logic core_rst;
   logic [1:0] mode_q;
   logic signed [SNR_WIDTH-1:0] sigma_act, ch_sigma;
   logic signed [DWIDTH-1:0] tx_i, tx_q, ch_i, ch_q, i_q, i_d, q_q, q_d;
   tx_top #(.DWIDTH(DWIDTH)) u_tx (.clk(clk), .rst(core_rst), .tx_I(tx_i), .tx_Q(tx_q));
   channel_with_noise #(.DWIDTH(DWIDTH), .SNR_WIDTH(SNR_WIDTH)) u_ch (
      .clk(clk), .rst(core_rst), .in_I(tx_i), .in_Q(tx_q), .sigma(ch_sigma), .out_I(ch_i), .out_Q(ch_q)
   );
   link_frame_ctrl #(
      .FRAME_LEN(FRAME_LEN), .FLUSH_CYCLES(FLUSH_CYCLES), .FCNT_W(FCNT_W), .SNR_WIDTH(SNR_WIDTH)
   ) u_ctrl (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .sigma_scale(sigma_scale),
      .sigma_wr(sigma_wr), .core_rst(core_rst), .valid(rx_valid), .frame_start(frame_start),
      .busy(busy), .frame_cnt(frame_cnt), .mode_q(mode_q), .sigma_act(sigma_act)
   );
   always_comb begin
      ch_sigma = mode_q == MODE_NO_NOISE ? '0 : sigma_act;
      i_d = mode_q == MODE_BYPASS ? tx_i : ch_i;
      q_d = mode_q == MODE_BYPASS ? tx_q : ch_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         i_q <= '0;
         q_q <= '0;
      end else begin
         i_q <= i_d;
         q_q <= q_d;
      end
   end
   assign rx_I = rx_valid ? i_q : '0;
   assign rx_Q = rx_valid ? q_q : '0;
endmodule

// File: tb/tb_link_emu_top.sv
// tb_link_emu_top: table-driven and sequence checks of run control, framing, sigma timing and modes
module tb_link_emu_top;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic [1:0] mode = 2'd0;
   logic signed [10:0] sigma_scale = '0;
   logic sigma_wr = 1'b0;
   logic signed [8:0] rx_I, rx_Q;
   logic rx_valid, frame_start, busy;
   logic [15:0] frame_cnt;
   int checks = 0;
   int failures = 0;
   int cap[5][32];

   typedef struct {
      int st, sp, wr, sig, adv, ev, efs, eb, efc, esig;
   } vec_t;
   vec_t tbl[17];

   link_emu_top #(.FRAME_LEN(8), .FLUSH_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .sigma_scale(sigma_scale),
      .sigma_wr(sigma_wr), .rx_I(rx_I), .rx_Q(rx_Q), .rx_valid(rx_valid), .frame_start(frame_start),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic capture(input logic [1:0] m, input int k);
      mode = m;
      start = 1'b1;
      step();
      start = 1'b0;
      mode = m ^ 2'b11;
      repeat (16) step();
      for (int i = 0; i < 16; i++) begin
         cap[k][i] = int'(rx_I);
         cap[k][i+16] = int'(rx_Q);
         step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      repeat (10) step();
      chk($sformatf("cap%0d_idle", k), int'(busy), 0);
   endtask

   initial begin
      tbl[0]  = '{1, 0, 0, 0,   1,  0, 0, 1, 0, 0};
      tbl[1]  = '{0, 0, 1, 40,  1,  0, 0, 1, 0, 40};
      tbl[2]  = '{0, 0, 0, 0,   14, 0, 0, 1, 0, 40};
      tbl[3]  = '{0, 0, 0, 0,   1,  1, 1, 1, 0, 40};
      tbl[4]  = '{0, 0, 1, 100, 1,  1, 0, 1, 0, 40};
      tbl[5]  = '{0, 0, 0, 0,   6,  1, 0, 1, 0, 40};
      tbl[6]  = '{0, 0, 0, 0,   1,  1, 1, 1, 1, 100};
      tbl[7]  = '{0, 0, 1, -5,  1,  1, 0, 1, 1, 100};
      tbl[8]  = '{0, 0, 0, 0,   7,  1, 1, 1, 2, 0};
      tbl[9]  = '{0, 0, 1, 30,  7,  1, 0, 1, 2, 0};
      tbl[10] = '{0, 0, 1, 50,  1,  1, 1, 1, 3, 30};
      tbl[11] = '{0, 0, 0, 0,   8,  1, 1, 1, 4, 50};
      tbl[12] = '{0, 0, 0, 0,   3,  1, 0, 1, 4, 50};
      tbl[13] = '{0, 1, 0, 0,   4,  1, 0, 1, 4, 50};
      tbl[14] = '{0, 0, 0, 0,   1,  0, 0, 0, 5, 50};
      tbl[15] = '{1, 1, 0, 0,   1,  0, 0, 0, 5, 50};
      tbl[16] = '{1, 0, 0, 0,   1,  0, 0, 1, 0, 50};

      repeat (3) step();
      rst = 1'b0;
      chk("rst_valid", int'(rx_valid), 0);
      chk("rst_fs", int'(frame_start), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_fcnt", int'(frame_cnt), 0);
      chk("rst_rxI", int'(rx_I), 0);

      for (int i = 0; i < 17; i++) begin
         start = tbl[i].st != 0;
         stop = tbl[i].sp != 0;
         sigma_wr = tbl[i].wr != 0;
         sigma_scale = 11'(tbl[i].sig);
         step();
         start = 1'b0;
         stop = 1'b0;
         sigma_wr = 1'b0;
         repeat (tbl[i].adv - 1) step();
         chk($sformatf("t%0d_valid", i), int'(rx_valid), tbl[i].ev);
         chk($sformatf("t%0d_fstart", i), int'(frame_start), tbl[i].efs);
         chk($sformatf("t%0d_busy", i), int'(busy), tbl[i].eb);
         chk($sformatf("t%0d_fcnt", i), int'(frame_cnt), tbl[i].efc);
         chk($sformatf("t%0d_sigma", i), int'(dut.u_ctrl.sigma_act), tbl[i].esig);
         if (!rx_valid) chk($sformatf("t%0d_rxzero", i), int'(rx_I) | int'(rx_Q), 0);
      end

      repeat (17) step();
      chk("run_before_rst", int'(rx_valid), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rrst_valid", int'(rx_valid), 0);
      chk("rrst_busy", int'(busy), 0);
      chk("rrst_fs", int'(frame_start), 0);
      chk("rrst_fcnt", int'(frame_cnt), 0);
      chk("rrst_rx", int'(rx_I) | int'(rx_Q), 0);
      chk("rrst_sigma", int'(dut.u_ctrl.sigma_act), 0);

      capture(2'd0, 0);
      sigma_scale = 11'sd200;
      sigma_wr = 1'b1;
      step();
      sigma_wr = 1'b0;
      chk("idle_sigma_wr", int'(dut.u_ctrl.sigma_act), 200);
      capture(2'd1, 1);
      capture(2'd0, 2);
      capture(2'd2, 3);
      capture(2'd2, 4);
      begin
         int d01, d02, d34, bad;
         d01 = 0; d02 = 0; d34 = 0; bad = 0;
         for (int i = 0; i < 32; i++) begin
            if (cap[0][i] != cap[1][i]) d01++;
            if (cap[0][i] != cap[2][i]) d02++;
            if (cap[3][i] != cap[4][i]) d34++;
            if (cap[3][i] != 64 && cap[3][i] != -64) bad++;
         end
         chk("nonoise_matches_sigma0", d01, 0);
         chk("noise_changes_output", int'(d02 > 0), 1);
         chk("bypass_repeatable", d34, 0);
         chk("bypass_qpsk_levels", bad, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/link_emu_top.md
# link_emu_top

Parametrised successor of the TX+channel top. Wraps `tx_top` (PRBS + QPSK mapper) and `channel_with_noise` (ISI FIR + Gaussian noise) behind a run-control FSM. Adds:
- start/stop control;
- pipeline-flush masking;
- framed output with a valid strobe;
- frame-synchronous noise-level updates;
- no-noise and channel-bypass modes.

Feeds the receiver/equaliser chain and the BER counters.

## Interface
Parameters:
- `DWIDTH`, 9, I/Q sample width (signed).
- `SNR_WIDTH`, 11, `sigma_scale` width (signed).
- `FRAME_LEN`, 1024, samples per frame (≥2).
- `FLUSH_CYCLES`, 16, masked cycles after start (≥1; ≥ channel latency).
- `FCNT_W`, 16, frame counter width.

Ports (one clock, `clk`; reset `rst` is synchronous, active-high):
- `clk` in 1 system clock
- `rst` in 1 synchronous active-high reset
- `start` in 1 run request pulse
- `stop` in 1 stop request pulse
- `mode` in 2 0 normal, 1 no-noise, 2 channel bypass, 3 treated as 0
- `sigma_scale` in SNR_WIDTH noise level, signed
- `sigma_wr` in 1 write strobe for `sigma_scale`
- `rx_I`, `rx_Q` out DWIDTH registered output samples
- `rx_valid` out 1 output sample valid
- `frame_start` out 1 high with first valid sample of each frame
- `busy` out 1 FSM not IDLE
- `frame_cnt` out FCNT_W completed frames since start

## Operation
- FSM states: IDLE, FLUSH, RUN, STOPPING.
- **IDLE**
  - Sub-blocks held in reset: `core_rst = rst | (state==IDLE)`. The PRBS restarts identically on every run.
  - `start` → FLUSH. On this transition, `mode` is latched to `mode_q`, `frame_cnt` is cleared and the flush counter is cleared.
- **FLUSH**
  - The core runs while `rx_valid` is held 0.
  - The counter counts 0..FLUSH_CYCLES-1, then the FSM moves to RUN with sample counter = 0.
- **RUN**
  - `rx_valid` = 1 every cycle. The sample counter counts 0..FRAME_LEN-1 and wraps.
  - `frame_start` = 1 when sample counter == 0.
  - On wrap, `frame_cnt` increments (modulo 2^FCNT_W).
  - `stop` → STOPPING.
- **STOPPING**
  - Identical to RUN until the last sample of the current frame (counter == FRAME_LEN-1), then → IDLE.
  - `frame_cnt` counts that frame.
  - A `stop` on the last sample of a frame goes directly to IDLE after that sample.
- **Sigma path**
  - `sigma_wr` loads a shadow register and sets `pend`.
  - The active sigma takes the shadow value:
    - immediately, when in IDLE or FLUSH;
    - otherwise, on the cycle the sample counter wraps to 0, so a frame never sees a mid-frame change.
  - Negative `sigma_scale` is clamped to 0 on write.
  - Reset value of active and shadow sigma is 0.
- **Modes**
  - mode 1 forces channel sigma to 0.
  - mode 2 drives the output from TX I/Q through the same output register, skipping the channel. Flush still applies.
  - `mode` changes outside IDLE→FLUSH are ignored.
- **Simultaneous events**
  - `start`+`stop` in IDLE: stay IDLE.
  - `start` outside IDLE: ignored.
  - `sigma_wr` on a wrap cycle: the previous pending value is applied and the new value stays pending for the next wrap.
- **Reset**
  - `rst` at any time forces IDLE on the next edge.
  - All outputs, counters, `pend` and sigma registers clear.

## Timing
- Reset values: `rx_I` = `rx_Q` = 0, `rx_valid` = 0, `frame_start` = 0, `busy` = 0, `frame_cnt` = 0.
- `start` sampled at edge t: `busy` = 1 from t+1; core out of reset from t+1.
- First `rx_valid` / `frame_start` at t+1+FLUSH_CYCLES.
- Output register adds 1 cycle after the channel (or TX in bypass). `rx_I`/`rx_Q` are 0 whenever `rx_valid` = 0.
- Last valid sample of a stopped frame at cycle k: `busy` = 0 at k+1. `rx_valid` = 0 from k+1.

## Structure
- Package `link_pkg` holds:
  - state encoding (IDLE = 0, FLUSH = 1, RUN = 2, STOPPING = 3);
  - mode constants;
  - a `clog2` function for counter widths.
- Sub-module `link_frame_ctrl` holds the FSM, the flush/sample/frame counters and the sigma shadow logic. It outputs `core_rst`, `valid`, `frame_start` and `sigma_act`.
- The top instantiates `tx_top`, `channel_with_noise`, `link_frame_ctrl`, the bypass mux and the output register.

## Test plan
- **Start after reset:** `rst` for 3 cycles, `start` at t, FLUSH_CYCLES = 16 → `rx_valid` and `frame_start` first high at t+17; `busy` high from t+1.
- **Frame counting:** FRAME_LEN = 8, run 3 frames → `frame_start` every 8 cycles; `frame_cnt` reads 1, 2, 3 at the wraps.
- **Mid-frame sigma write:** `sigma_wr` with 100 mid-frame → channel sigma unchanged until the next wrap; −5 written → active value 0.
- **Graceful stop:** `stop` at sample 3 of an 8-sample frame → 5 more valid samples, then `busy` = 0. Two runs in mode 2 give identical rx sequences.
- **Event collisions:** `start`+`stop` together in IDLE → stays IDLE. `rst` during RUN → all outputs 0 on the next cycle, `frame_cnt` = 0.
